// File: rtl/cpu_control_pkg.sv
// Shared definitions for the single-cycle CPU control path: opcodes, ALU select codes,
// instruction field positions, controller states and the opcode decoder.
package cpu_defs;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_MULT  = 8'd6;
  localparam logic [7:0] OP_SHIFT = 8'd7;
  localparam logic [7:0] OP_J     = 8'd8;
  localparam logic [7:0] OP_BEQ   = 8'd9;
  localparam logic [7:0] OP_BNE   = 8'd10;
  localparam logic [7:0] OP_LWD   = 8'd11;
  localparam logic [7:0] OP_LWI   = 8'd12;
  localparam logic [7:0] OP_SWD   = 8'd13;
  localparam logic [7:0] OP_SWI   = 8'd14;

  // ALU SELECT codes, shared with the ALU
  localparam logic [2:0] ALU_FWD   = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_MULT  = 3'd4;
  localparam logic [2:0] ALU_SHIFT = 3'd5;

  localparam int OPCODE_LSB = 24;
  localparam int RD_LSB     = 16;
  localparam int RS1_LSB    = 8;
  localparam int RS2_LSB    = 0;
  localparam int REG_W      = 3;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       imm_sel;
    logic       neg_sel;
    logic       we;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [7:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_LOADI: begin c.aluop = ALU_FWD;   c.imm_sel = 1'b1; c.we = 1'b1; end
      OP_MOV:   begin c.aluop = ALU_FWD;   c.we = 1'b1; end
      OP_ADD:   begin c.aluop = ALU_ADD;   c.we = 1'b1; end
      OP_SUB:   begin c.aluop = ALU_ADD;   c.neg_sel = 1'b1; c.we = 1'b1; end
      OP_AND:   begin c.aluop = ALU_AND;   c.we = 1'b1; end
      OP_OR:    begin c.aluop = ALU_OR;    c.we = 1'b1; end
      OP_MULT:  begin c.aluop = ALU_MULT;  c.we = 1'b1; end
      OP_SHIFT: begin c.aluop = ALU_SHIFT; c.imm_sel = 1'b1; c.we = 1'b1; end
      OP_J:     begin c.jump = 1'b1; end
      OP_BEQ:   begin c.aluop = ALU_ADD;   c.neg_sel = 1'b1; c.beq = 1'b1; end
      OP_BNE:   begin c.aluop = ALU_ADD;   c.neg_sel = 1'b1; c.bne = 1'b1; end
      OP_LWD:   begin c.mem_read = 1'b1;   c.we = 1'b1; end
      OP_LWI:   begin c.mem_read = 1'b1;   c.imm_sel = 1'b1; c.we = 1'b1; end
      OP_SWD:   begin c.mem_write = 1'b1; end
      OP_SWI:   begin c.mem_write = 1'b1;  c.imm_sel = 1'b1; end
      default:  begin c.illegal = 1'b1; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_control_pc_unit.sv
// Program counter: register, sequential +PC_STEP adder, branch target adder and next-PC mux.
module pc_unit #(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        advance_i,
  input  logic        take_i,
  input  logic [7:0]  offset_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] seq_pc;
  logic [31:0] target_pc;

  assign seq_pc    = pc_q + PC_STEP;
  // Offset counts words, so sign-extend then scale to bytes
  assign target_pc = seq_pc + {{22{offset_i[7]}}, offset_i, 2'b00};

  always_comb begin
    pc_d = pc_q;
    if (advance_i) begin
      pc_d = take_i ? target_pc : seq_pc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_control.sv
// Instruction-side controller: owns the PC, decodes instructions into datapath controls
// and stalls on instruction/data memory busywait.
module cpu_control
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_BUSYWAIT,
  input  logic        MEM_BUSYWAIT,
  input  logic        ZERO,
  output logic [31:0] PC,
  output logic [2:0]  ALUOP,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic [7:0]  IMMEDIATE,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        WRITEENABLE,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic        ILLEGAL,
  output state_t      DBG_STATE
);

  ctrl_t  dec;
  state_t state_q;
  state_t state_d;
  logic   illegal_q;
  logic   illegal_d;
  logic   mem_req;
  logic   advance;
  logic   take;
  logic   we;
  logic   mr;
  logic   mw;
  logic   unused_instr_bits;

  assign dec     = decode(INSTRUCTION[OPCODE_LSB +: 8]);
  assign mem_req = dec.mem_read | dec.mem_write;
  assign take    = dec.jump | (dec.beq & ZERO) | (dec.bne & ~ZERO);

  // Handshake: a memory request is accepted on the cycle it is asserted with
  // MEM_BUSYWAIT low; while busywait is high the request is held steady.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    we      = 1'b0;
    mr      = 1'b0;
    mw      = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (INSTR_BUSYWAIT) begin
          state_d = ST_STALL;
        end else begin
          mr = dec.mem_read;
          mw = dec.mem_write;
          if (mem_req && MEM_BUSYWAIT) begin
            state_d = ST_STALL;
          end else begin
            we      = dec.we;
            advance = 1'b1;
          end
        end
      end
      ST_STALL: begin
        // The fetched word is only trusted once instruction memory is ready
        if (!INSTR_BUSYWAIT) begin
          mr = dec.mem_read;
          mw = dec.mem_write;
          we = dec.mem_read & ~MEM_BUSYWAIT;
          if (!MEM_BUSYWAIT) state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign illegal_d = illegal_q | (advance & dec.illegal);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_BOOT;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  pc_unit #(
    .PC_RESET (PC_RESET),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .advance_i (advance),
    .take_i    (take),
    .offset_i  (INSTRUCTION[RD_LSB +: 8]),
    .pc_o      (PC)
  );

  assign ALUOP       = dec.aluop;
  assign WRITEREG    = INSTRUCTION[RD_LSB +: REG_W];
  assign READREG1    = INSTRUCTION[RS1_LSB +: REG_W];
  assign READREG2    = INSTRUCTION[RS2_LSB +: REG_W];
  assign IMMEDIATE   = INSTRUCTION[RS2_LSB +: 8];
  assign IMM_SEL     = dec.imm_sel;
  assign NEG_SEL     = dec.neg_sel;
  assign WRITEENABLE = we & ~RESET;
  assign MEM_READ    = mr & ~RESET;
  assign MEM_WRITE   = mw & ~RESET;
  assign ILLEGAL     = illegal_q;
  assign DBG_STATE   = state_q;

  assign unused_instr_bits = ^INSTRUCTION[15:11];

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: a table-driven instruction model checked every cycle,
// plus hand-computed PC and strobe expectations at key points.
module tb_cpu_control;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        ibusy;
  logic        mbusy;
  logic        zero;
  logic [31:0] pc;
  logic [2:0]  aluop;
  logic [2:0]  rr1;
  logic [2:0]  rr2;
  logic [2:0]  wr;
  logic [7:0]  imm;
  logic        imm_sel;
  logic        neg_sel;
  logic        we;
  logic        mr;
  logic        mw;
  logic        ill;
  logic [1:0]  dbg_state_unused;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  cpu_control dut (
    .CLK            (clk),
    .RESET          (rst),
    .INSTRUCTION    (instr),
    .INSTR_BUSYWAIT (ibusy),
    .MEM_BUSYWAIT   (mbusy),
    .ZERO           (zero),
    .PC             (pc),
    .ALUOP          (aluop),
    .READREG1       (rr1),
    .READREG2       (rr2),
    .WRITEREG       (wr),
    .IMMEDIATE      (imm),
    .IMM_SEL        (imm_sel),
    .NEG_SEL        (neg_sel),
    .WRITEENABLE    (we),
    .MEM_READ       (mr),
    .MEM_WRITE      (mw),
    .ILLEGAL        (ill),
    .DBG_STATE      (dbg_state_unused)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: opcode tables (bit n = opcode n) ----------------
  localparam logic [14:0] IMM_MASK = 15'h5081;
  localparam logic [14:0] NEG_MASK = 15'h0608;
  localparam logic [14:0] WE_MASK  = 15'h18FF;
  localparam logic [14:0] MR_MASK  = 15'h1800;
  localparam logic [14:0] MW_MASK  = 15'h6000;
  localparam logic [2:0]  ALU_TAB [0:14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                             3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};

  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_wait;
  logic        m_ill;

  logic [7:0]  op;
  logic        legal;
  logic [2:0]  e_alu;
  logic        e_imm, e_neg, raw_we, raw_mr, raw_mw, memop;
  logic        e_we, e_mr, e_mw;
  logic        retire, taken;
  logic [31:0] nxt_pc;

  always_comb begin
    op     = instr[31:24];
    legal  = (op < 8'd15);
    e_alu  = 3'd0;
    e_imm  = 1'b0;
    e_neg  = 1'b0;
    raw_we = 1'b0;
    raw_mr = 1'b0;
    raw_mw = 1'b0;
    if (legal) begin
      e_alu  = ALU_TAB[op[3:0]];
      e_imm  = IMM_MASK[op[3:0]];
      e_neg  = NEG_MASK[op[3:0]];
      raw_we = WE_MASK[op[3:0]];
      raw_mr = MR_MASK[op[3:0]];
      raw_mw = MW_MASK[op[3:0]];
    end
    memop  = raw_mr | raw_mw;
    retire = !rst && !m_boot && !m_wait && !ibusy && !(memop && mbusy);
    e_we   = 1'b0;
    e_mr   = 1'b0;
    e_mw   = 1'b0;
    if (!(rst || m_boot || ibusy)) begin
      e_mr = raw_mr;
      e_mw = raw_mw;
      if (m_wait) e_we = raw_mr && !mbusy;
      else        e_we = raw_we && !(memop && mbusy);
    end
    taken  = (op == 8'd8) || (op == 8'd9 && zero) || (op == 8'd10 && !zero);
    nxt_pc = m_pc;
    if (retire) nxt_pc = m_pc + 32'd4 + (taken ? {{22{instr[23]}}, instr[23:16], 2'b00} : 32'd0);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc   <= 32'd0;
      m_boot <= 1'b1;
      m_wait <= 1'b0;
      m_ill  <= 1'b0;
    end else begin
      m_pc   <= nxt_pc;
      m_boot <= 1'b0;
      m_wait <= m_boot ? 1'b0 : (m_wait ? (ibusy || mbusy) : (ibusy || (memop && mbusy)));
      m_ill  <= m_ill | (retire && !legal);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pc",      pc,      m_pc);
      chk("m_aluop",   {29'd0, aluop}, {29'd0, e_alu});
      chk("m_readreg1",{29'd0, rr1}, {29'd0, instr[10:8]});
      chk("m_readreg2",{29'd0, rr2}, {29'd0, instr[2:0]});
      chk("m_writereg",{29'd0, wr},  {29'd0, instr[18:16]});
      chk("m_imm",     {24'd0, imm}, {24'd0, instr[7:0]});
      chk("m_imm_sel", {31'd0, imm_sel}, {31'd0, e_imm});
      chk("m_neg_sel", {31'd0, neg_sel}, {31'd0, e_neg});
      chk("m_we",      {31'd0, we},  {31'd0, e_we});
      chk("m_mem_read",{31'd0, mr},  {31'd0, e_mr});
      chk("m_mem_write",{31'd0, mw}, {31'd0, e_mw});
      chk("m_illegal", {31'd0, ill}, {31'd0, m_ill});
    end
  end

  // ---------------- driver ----------------
  task automatic apply(input logic [31:0] ins, input logic ib, input logic mb, input logic z);
    instr = ins;
    ibusy = ib;
    mbusy = mb;
    zero  = z;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_LOADI = 32'h0003002A;
  localparam logic [31:0] I_ADD   = 32'h02010203;
  localparam logic [31:0] I_SUB   = 32'h03020104;
  localparam logic [31:0] I_AND   = 32'h04030102;
  localparam logic [31:0] I_OR    = 32'h05010203;
  localparam logic [31:0] I_BEQ   = 32'h09FE0102;
  localparam logic [31:0] I_BNE   = 32'h0A020102;
  localparam logic [31:0] I_J     = 32'h08010000;
  localparam logic [31:0] I_LWD   = 32'h0B050003;
  localparam logic [31:0] I_SWI   = 32'h0E000107;
  localparam logic [31:0] I_MULT  = 32'h06020304;
  localparam logic [31:0] I_SHIFT = 32'h07010205;
  localparam logic [31:0] I_MOV   = 32'h01040500;
  localparam logic [31:0] I_LWI   = 32'h0C060010;
  localparam logic [31:0] I_SWD   = 32'h0D000102;
  localparam logic [31:0] I_ILL   = 32'hFF000000;

  initial begin
    rst = 1'b0;
    instr = I_LOADI; ibusy = 1'b0; mbusy = 1'b0; zero = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    apply(I_LOADI, 0, 0, 0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_we", {31'd0, we}, 32'd0);
    tick; tick;
    rst = 1'b0;

    // boot cycle
    apply(I_LOADI, 0, 0, 0);
    chk("boot_pc", pc, 32'h0);
    chk("boot_we", {31'd0, we}, 32'd0);
    tick;

    // loadi
    apply(I_LOADI, 0, 0, 0);
    chk("loadi_aluop", {29'd0, aluop}, 32'd0);
    chk("loadi_imm_sel", {31'd0, imm_sel}, 32'd1);
    chk("loadi_writereg", {29'd0, wr}, 32'd3);
    chk("loadi_immediate", {24'd0, imm}, 32'h2A);
    chk("loadi_we", {31'd0, we}, 32'd1);
    tick;
    apply(I_ADD, 0, 0, 0);
    chk("loadi_pc_next", pc, 32'h4);
    chk("add_aluop", {29'd0, aluop}, 32'd1);
    tick;
    apply(I_SUB, 0, 0, 0);
    chk("sub_neg_sel", {31'd0, neg_sel}, 32'd1);
    tick;
    apply(I_AND, 0, 0, 0);
    tick;

    // beq taken at 0x10, then not taken
    apply(I_BEQ, 0, 0, 1);
    chk("beq_pc", pc, 32'h10);
    chk("beq_we", {31'd0, we}, 32'd0);
    tick;
    apply(I_OR, 0, 0, 0);
    chk("beq_taken_pc", pc, 32'h0C);
    tick;
    apply(I_BEQ, 0, 0, 0);
    tick;
    apply(I_BNE, 0, 0, 0);
    chk("beq_not_taken_pc", pc, 32'h14);
    tick;
    apply(I_J, 0, 0, 0);
    chk("bne_taken_pc", pc, 32'h20);
    tick;

    // instruction stall during add
    apply(I_ADD, 1, 0, 0);
    chk("istall_pc", pc, 32'h28);
    chk("istall_we", {31'd0, we}, 32'd0);
    tick;
    apply(I_ADD, 1, 0, 0);
    chk("istall_we2", {31'd0, we}, 32'd0);
    tick;
    apply(I_ADD, 0, 0, 0);
    tick;
    apply(I_ADD, 0, 0, 0);
    chk("istall_resume_we", {31'd0, we}, 32'd1);
    tick;

    // data stall on lwd: busywait 3 cycles
    for (int i = 0; i < 3; i++) begin
      apply(I_LWD, 0, 1, 0);
      chk("dstall_pc", pc, 32'h2C);
      chk("dstall_mr", {31'd0, mr}, 32'd1);
      chk("dstall_we", {31'd0, we}, 32'd0);
      tick;
    end
    apply(I_LWD, 0, 0, 0);
    chk("dstall_release_we", {31'd0, we}, 32'd1);
    chk("dstall_release_pc", pc, 32'h2C);
    tick;
    apply(I_LWD, 0, 0, 0);
    tick;
    apply(I_SWI, 0, 0, 0);
    chk("lwd_pc_next", pc, 32'h30);
    chk("swi_mw", {31'd0, mw}, 32'd1);
    chk("swi_we", {31'd0, we}, 32'd0);
    tick;
    apply(I_MULT, 0, 0, 0);  tick;
    apply(I_SHIFT, 0, 0, 0);
    chk("shift_aluop", {29'd0, aluop}, 32'd5);
    tick;
    apply(I_MOV, 0, 0, 0);   tick;
    apply(I_LWI, 0, 0, 0);   tick;

    // both busywaits high on swd
    apply(I_SWD, 1, 1, 0);
    chk("both_busy_pc", pc, 32'h44);
    chk("both_busy_mw", {31'd0, mw}, 32'd0);
    tick;
    apply(I_SWD, 0, 1, 0);
    chk("mem_busy_mw", {31'd0, mw}, 32'd1);
    tick;
    apply(I_SWD, 0, 0, 0);   tick;
    apply(I_SWD, 0, 0, 0);   tick;

    // illegal opcode
    apply(I_ILL, 0, 0, 0);
    chk("ill_pc", pc, 32'h48);
    chk("ill_we", {31'd0, we}, 32'd0);
    chk("ill_flag_before", {31'd0, ill}, 32'd0);
    tick;
    apply(I_ADD, 0, 1, 0);
    chk("ill_pc_next", pc, 32'h4C);
    chk("ill_flag_set", {31'd0, ill}, 32'd1);
    chk("add_ignores_mbusy_we", {31'd0, we}, 32'd1);
    tick;
    apply(I_LOADI, 0, 0, 0);
    chk("ill_sticky", {31'd0, ill}, 32'd1);
    tick;

    // reset asserted mid-cycle during a data stall
    apply(I_LWD, 0, 1, 0);
    tick;
    apply(I_LWD, 0, 1, 0);
    rst = 1'b1;
    #1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_mr", {31'd0, mr}, 32'd0);
    chk("midrst_ill", {31'd0, ill}, 32'd0);
    tick;
    rst = 1'b0;
    apply(I_LOADI, 0, 0, 0);
    chk("midrst_boot_we", {31'd0, we}, 32'd0);
    tick;
    apply(I_LOADI, 0, 0, 0);
    tick;
    apply(I_ADD, 0, 0, 0);
    chk("midrst_run_pc", pc, 32'h4);
    tick;

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
